// File: rtl/fp_result_capture_pio.sv
// fp_result_capture_pio: multi-channel read-mostly Avalon-MM PIO that captures
// FPGA-side result words for the HPS. Each channel has a registered data view,
// a sticky change flag (write-1-to-clear), an IRQ mask bit and a saturating
// change counter. All per-channel IRQs combine into one level interrupt.
// Optional build macro FP_RESULT_SYNC_EN adds a 2-flop input synchroniser for
// results that come from an asynchronous clock domain.
module fp_result_capture_pio #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int COUNT_W = 16,
  parameter int CH_AW   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CH_AW+1:0]         address,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic [31:0]              readdata,
  output logic                     irq
);

  localparam logic [COUNT_W-1:0] CountMax = '1;

  logic [DATA_W-1:0]        data_q     [NUM_CH];
  logic [DATA_W-1:0]        data_d     [NUM_CH];
  logic [COUNT_W-1:0]       chgCount_q [NUM_CH];
  logic [COUNT_W-1:0]       chgCount_d [NUM_CH];
  logic [DATA_W-1:0]        sample     [NUM_CH];
  logic [NUM_CH-1:0]        chgFlag_q, chgFlag_d;
  logic [NUM_CH-1:0]        irqMask_q, irqMask_d;
  logic [NUM_CH-1:0]        chg;
  logic                     primed_q, primed_d;
  logic [31:0]              readdata_d;
  logic [NUM_CH*DATA_W-1:0] samplePacked;

  logic        wrEn;
  logic [1:0]  regSel;
  logic [31:0] chIdx;
  logic        unusedWriteBits;

  assign wrEn            = !write_n;
  assign regSel          = address[1:0];
  assign chIdx           = 32'(address[CH_AW+1:2]);
  assign unusedWriteBits = ^writedata[31:1];

`ifdef FP_RESULT_SYNC_EN
  logic [NUM_CH*DATA_W-1:0] sync1_q, sync2_q;
  logic [1:0]               fill_q, fill_d;

  // Two-flop synchroniser and a fill counter tracking how many valid stages it holds
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      fill_q  <= fill_d;
    end
  end

  // Count up to full and hold, so change detection waits for real data
  always_comb begin
    fill_d = fill_q;
    if (fill_q != 2'd2) begin
      fill_d = fill_q + 2'd1;
    end
  end

  assign samplePacked = sync2_q;
  assign primed_d     = (fill_q == 2'd2);
`else
  assign samplePacked = in_port;
  assign primed_d     = 1'b1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : gSample
    assign sample[g] = samplePacked[g*DATA_W +: DATA_W];
    assign chg[g]    = primed_q && (sample[g] != data_q[g]);
  end

  // Per-channel next state: a detected change always beats a same-edge clear
  always_comb begin
    chgFlag_d = chgFlag_q;
    irqMask_d = irqMask_q;
    for (int c = 0; c < NUM_CH; c++) begin
      data_d[c]     = sample[c];
      chgCount_d[c] = chgCount_q[c];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (chg[c]) begin
        chgFlag_d[c] = 1'b1;
      end else if (wrEn && (chIdx == c) && (regSel == 2'd1) && writedata[0]) begin
        chgFlag_d[c] = 1'b0;
      end

      if (wrEn && (chIdx == c) && (regSel == 2'd2)) begin
        irqMask_d[c] = writedata[0];
      end

      if (wrEn && (chIdx == c) && (regSel == 2'd3)) begin
        chgCount_d[c] = chg[c] ? COUNT_W'(1) : '0;
      end else if (chg[c] && (chgCount_q[c] != CountMax)) begin
        chgCount_d[c] = chgCount_q[c] + 1'b1;
      end
    end
  end

  // Read mux; unmapped channel indices fall through to zero
  always_comb begin
    readdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (chIdx == c) begin
        case (regSel)
          2'd0:    readdata_d = 32'(data_q[c]);
          2'd1:    readdata_d = {31'b0, chgFlag_q[c]};
          2'd2:    readdata_d = {31'b0, irqMask_q[c]};
          default: readdata_d = 32'(chgCount_q[c]);
        endcase
      end
    end
  end

  // State registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c]     <= '0;
        chgCount_q[c] <= '0;
      end
      chgFlag_q <= '0;
      irqMask_q <= '0;
      primed_q  <= 1'b0;
      readdata  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        data_q[c]     <= data_d[c];
        chgCount_q[c] <= chgCount_d[c];
      end
      chgFlag_q <= chgFlag_d;
      irqMask_q <= irqMask_d;
      primed_q  <= primed_d;
      readdata  <= readdata_d;
    end
  end

  assign irq = |(chgFlag_q & irqMask_q);

endmodule

// File: tb/tb_fp_result_capture_pio.sv
// Directed bench for fp_result_capture_pio, built with three channels and a
// 4-bit change counter so that out-of-range channels and saturation are reachable.
module tb_fp_result_capture_pio;

  localparam int NUM_CH  = 3;
  localparam int DATA_W  = 32;
  localparam int COUNT_W = 4;
  localparam int CH_AW   = 2;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [CH_AW+1:0]         address;
  logic                     write_n;
  logic [31:0]              writedata;
  logic [NUM_CH*DATA_W-1:0] in_port;
  logic [31:0]              readdata;
  logic                     irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_result_capture_pio #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .COUNT_W(COUNT_W),
    .CH_AW  (CH_AW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .write_n  (write_n),
    .writedata(writedata),
    .in_port  (in_port),
    .readdata (readdata),
    .irq      (irq)
  );

  task automatic doRead(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    write_n = 1'b1;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic doWrite(input logic [3:0] a, input logic [31:0] v);
    @(negedge clk);
    address   = a;
    writedata = v;
    write_n   = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
  endtask

`ifdef FP_RESULT_SYNC_EN
  task automatic test_sync;
    reset_n = 1'b0; write_n = 1'b1; address = 4'd1; writedata = '0; in_port = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (readdata !== 32'h0) begin
        bad++;
        $display("[TB] FAIL sync_no_reset_flag: got %h want %h", readdata, 32'h0);
      end
    end
    address = 4'd0;
    @(negedge clk);
    in_port[31:0] = 32'hA5;
    repeat (3) @(negedge clk);
    total++;
    if (readdata !== 32'h0) begin
      bad++;
      $display("[TB] FAIL sync_early: got %h want %h", readdata, 32'h0);
    end
    @(negedge clk);
    total++;
    if (readdata !== 32'hA5) begin
      bad++;
      $display("[TB] FAIL sync_data: got %h want %h", readdata, 32'hA5);
    end
    address = 4'd1;
    @(negedge clk);
    total++;
    if (readdata !== 32'h1) begin
      bad++;
      $display("[TB] FAIL sync_flag: got %h want %h", readdata, 32'h1);
    end
  endtask
`else
  task automatic test_reset;
    logic [31:0] d;
    reset_n = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    in_port = '0;
    in_port[31:0] = 32'h3F800000;
    repeat (2) @(negedge clk);
    total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got rd=%h irq=%b want rd=0 irq=0", readdata, irq);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    doRead(4'd0, d);
    total++;
    if (d !== 32'h3F800000) begin
      bad++;
      $display("[TB] FAIL reset_data: got %h want %h", d, 32'h3F800000);
    end
    doRead(4'd1, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_no_flag: got %h want %h", d, 32'h0);
    end
    doRead(4'd3, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_no_count: got %h want %h", d, 32'h0);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_irq_mask;
    logic [31:0] d;
    doWrite(4'd2, 32'h1);
    doRead(4'd2, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("[TB] FAIL mask_readback: got %h want %h", d, 32'h1);
    end
    @(negedge clk);
    in_port[31:0] = 32'h40000000;
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL irq_assert: got %b want 1", irq);
    end
    doRead(4'd1, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("[TB] FAIL chg_flag_set: got %h want %h", d, 32'h1);
    end
    doRead(4'd3, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("[TB] FAIL chg_count_one: got %h want %h", d, 32'h1);
    end
    doRead(4'd0, d);
    total++;
    if (d !== 32'h40000000) begin
      bad++;
      $display("[TB] FAIL data_update: got %h want %h", d, 32'h40000000);
    end
    doWrite(4'd1, 32'h1);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL irq_clear: got %b want 0", irq);
    end
    doRead(4'd1, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL w1c_clear: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    @(negedge clk);
    in_port[63:32] = 32'h1;
    address = 4'd5; writedata = 32'h1; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    doRead(4'd5, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("[TB] FAIL set_beats_w1c: got %h want %h", d, 32'h1);
    end
    doRead(4'd7, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("[TB] FAIL count_during_w1c: got %h want %h", d, 32'h1);
    end
    @(negedge clk);
    in_port[63:32] = 32'h2;
    doRead(4'd7, d);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("[TB] FAIL count_two: got %h want %h", d, 32'h2);
    end
    @(negedge clk);
    in_port[63:32] = 32'h3;
    address = 4'd7; writedata = 32'h0; write_n = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    doRead(4'd7, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("[TB] FAIL clear_with_chg: got %h want %h", d, 32'h1);
    end
    doWrite(4'd5, 32'h0);
    doRead(4'd5, d);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("[TB] FAIL w0_no_effect: got %h want %h", d, 32'h1);
    end
    doWrite(4'd5, 32'h1);
    doRead(4'd5, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL ch1_w1c: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_saturate;
    logic [31:0] d;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      in_port[95:64] = 32'(k);
    end
    doRead(4'd11, d);
    total++;
    if (d !== 32'd14) begin
      bad++;
      $display("[TB] FAIL count_14: got %h want %h", d, 32'd14);
    end
    for (int k = 15; k <= 20; k++) begin
      @(negedge clk);
      in_port[95:64] = 32'(k);
    end
    doRead(4'd11, d);
    total++;
    if (d !== 32'd15) begin
      bad++;
      $display("[TB] FAIL count_saturate: got %h want %h", d, 32'd15);
    end
    doRead(4'd8, d);
    total++;
    if (d !== 32'd20) begin
      bad++;
      $display("[TB] FAIL ch2_data: got %h want %h", d, 32'd20);
    end
    doWrite(4'd11, 32'h0);
    doRead(4'd11, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL count_clear: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_out_of_range;
    logic [31:0] d;
    for (int a = 12; a <= 15; a++) begin
      doRead(4'(a), d);
      total++;
      if (d !== 32'h0) begin
        bad++;
        $display("[TB] FAIL oor_read_%0d: got %h want %h", a, d, 32'h0);
      end
    end
    doWrite(4'd14, 32'h1);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL oor_write_irq: got %b want 0", irq);
    end
    doRead(4'd10, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL oor_no_alias: got %h want %h", d, 32'h0);
    end
    doWrite(4'd0, 32'h12345678);
    doRead(4'd0, d);
    total++;
    if (d !== 32'h40000000) begin
      bad++;
      $display("[TB] FAIL data_write_ignored: got %h want %h", d, 32'h40000000);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic [31:0] expZero [6];
    logic [3:0]  zeroAddr [6];
    zeroAddr = '{4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd3};
    expZero  = '{default: 32'h0};
    doWrite(4'd6, 32'h1);
    @(negedge clk);
    in_port[63:32] = 32'h4;
    @(negedge clk);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("[TB] FAIL pre_reset_irq: got %b want 1", irq);
    end
    @(negedge clk);
    address = 4'd10; writedata = 32'h1; write_n = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    total++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset_out: got rd=%h irq=%b want rd=0 irq=0", readdata, irq);
    end
    write_n = 1'b1; reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      doRead(zeroAddr[i], d);
      total++;
      if (d !== expZero[i]) begin
        bad++;
        $display("[TB] FAIL post_reset_addr%0d: got %h want %h", zeroAddr[i], d, expZero[i]);
      end
    end
    doRead(4'd11, d);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("[TB] FAIL post_reset_count2: got %h want %h", d, 32'h0);
    end
    doRead(4'd4, d);
    total++;
    if (d !== 32'h4) begin
      bad++;
      $display("[TB] FAIL post_reset_data1: got %h want %h", d, 32'h4);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_irq: got %b want 0", irq);
    end
  endtask
`endif

  initial begin
`ifdef FP_RESULT_SYNC_EN
    test_sync();
`else
    test_reset();
    test_irq_mask();
    test_collision();
    test_saturate();
    test_out_of_range();
    test_reset_mid();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
